// File: rtl/sw_debouncer_if.sv
// Switch-conditioning bus: raw switch levels and tick strobe in,
// debounced levels plus rise/fall/changed event flags out.
interface sw_debouncer_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] i_sw_raw;
   logic             i_tick;
   logic [WIDTH-1:0] o_sw;
   logic [WIDTH-1:0] o_rise;
   logic [WIDTH-1:0] o_fall;
   logic             o_changed;

   modport master (
      output i_sw_raw,
      output i_tick,
      input  o_sw,
      input  o_rise,
      input  o_fall,
      input  o_changed
   );

   modport slave (
      input  i_sw_raw,
      input  i_tick,
      output o_sw,
      output o_rise,
      output o_fall,
      output o_changed
   );
endinterface

// File: rtl/sw_debouncer.sv
// Synchronises a raw switch bus into the core clock domain and debounces
// each bit independently, producing stable levels plus edge event pulses.
module sw_debouncer #(
   parameter  int WIDTH        = 32,
   parameter  int SYNC_STAGES  = 2,
   parameter  int STABLE_TICKS = 16,
   localparam int CNT_W        = $clog2(STABLE_TICKS + 1)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   sw_debouncer_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] sync_chain_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   logic [WIDTH-1:0] sw_q,   sw_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             changed_q, changed_d;

   // Plain register chain; the last stage is the only one the debouncer reads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_chain_q[s] <= '0;
         end
      end else begin
         sync_chain_q[0] <= bus.i_sw_raw;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_chain_q[s] <= sync_chain_q[s-1];
         end
      end
   end

   assign sync_q = sync_chain_q[SYNC_STAGES-1];

   // A matching level clears the count even on non-tick cycles, so any
   // return to the accepted level restarts qualification from zero.
   always_comb begin
      sw_d   = sw_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_q[i] == sw_q[i]) begin
            cnt_d[i] = '0;
         end else if (bus.i_tick) begin
            if (cnt_q[i] == CNT_LAST) begin
               cnt_d[i]  = '0;
               sw_d[i]   = sync_q[i];
               rise_d[i] = sync_q[i];
               fall_d[i] = ~sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         sw_q      <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         sw_q      <= sw_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign bus.o_sw      = sw_q;
   assign bus.o_rise    = rise_q;
   assign bus.o_fall    = fall_q;
   assign bus.o_changed = changed_q;

endmodule
